// File: rtl/cpu_seq_pkg.sv
// Shared types and defaults for the 6502 sequencer slice.
// Imported by cpu_sequencer and cpu_watchdog.
package cpu_seq_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DMA  = 2'd2
  } seq_state_t;

  localparam int CE_DIV_DEF      = 4;
  localparam int IRQ_BIT_DEF     = 5;
  localparam int WDOG_FRAMES_DEF = 8;
  localparam int RST_CYCLES_DEF  = 16;
  localparam int LC_W            = 8;

endpackage

// File: rtl/cpu_watchdog.sv
// Frame-based watchdog: counts unkicked frames and fires
// a one-clk pulse when the budget runs out.
module cpu_watchdog
  import cpu_seq_pkg::*;
#(
  parameter int WDOG_FRAMES = WDOG_FRAMES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  input  logic wdog_kick,
  input  logic en,
  output logic fire,
  output logic wdog_fired
);

  localparam int WW = $clog2(WDOG_FRAMES + 1);
  localparam logic [WW-1:0] WLAST = WW'(WDOG_FRAMES - 1);

  logic [WW-1:0] wcnt;

  // A kick in the same cycle as frame_start always wins.
  assign fire = en && frame_start && !wdog_kick
             && (wcnt == WLAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt       <= '0;
      wdog_fired <= 1'b0;
    end else begin
      wdog_fired <= fire;
      if (wdog_kick || fire) begin
        wcnt <= '0;
      end else if (en && frame_start) begin
        wcnt <= wcnt + WW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// CPU sequencer: clock enable, IRQ timebase, DMA bus
// arbitration and CPU reset with watchdog recovery.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int CE_DIV      = CE_DIV_DEF,
  parameter int IRQ_BIT     = IRQ_BIT_DEF,
  parameter int WDOG_FRAMES = WDOG_FRAMES_DEF,
  parameter int RST_CYCLES  = RST_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic line_strobe,
  input  logic frame_start,
  input  logic wdog_kick,
  input  logic dma_req,
  output logic ce2H,
  output logic IRQCLK,
  output logic dma_gnt,
  output logic cpu_reset_n,
  output logic wdog_fired
);

  localparam int CW = $clog2(CE_DIV);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] CLAST = CW'(CE_DIV - 1);
  localparam logic [RW-1:0] RLAST = RW'(RST_CYCLES - 1);

  seq_state_t      state;
  logic [CW-1:0]   cdiv;
  logic [CW-1:0]   cdiv_nxt;
  logic [RW-1:0]   rcnt;
  logic [LC_W-1:0] lc;
  logic            wd_fire;
  logic            wd_en;

  assign cdiv_nxt = (cdiv == CLAST) ? '0 : cdiv + CW'(1);
  assign wd_en    = (state != HOLD);

  cpu_watchdog #(
    .WDOG_FRAMES(WDOG_FRAMES)
  ) u_wdog (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .wdog_kick  (wdog_kick),
    .en         (wd_en),
    .fire       (wd_fire),
    .wdog_fired (wdog_fired)
  );

  // Line counter and IRQ timebase run regardless of CPU state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lc     <= '0;
      IRQCLK <= 1'b0;
    end else begin
      IRQCLK <= lc[IRQ_BIT];
      if (frame_start) begin
        lc <= '0;
      end else if (line_strobe) begin
        lc <= lc + LC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= HOLD;
      cdiv        <= '0;
      rcnt        <= '0;
      ce2H        <= 1'b0;
      dma_gnt     <= 1'b0;
      cpu_reset_n <= 1'b0;
    end else if (wd_fire) begin
      state       <= HOLD;
      cdiv        <= '0;
      rcnt        <= '0;
      ce2H        <= 1'b0;
      dma_gnt     <= 1'b0;
      cpu_reset_n <= 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          cdiv    <= '0;
          ce2H    <= 1'b0;
          dma_gnt <= 1'b0;
          if (rcnt == RLAST) begin
            state       <= RUN;
            rcnt        <= '0;
            cpu_reset_n <= 1'b1;
          end else begin
            rcnt <= rcnt + RW'(1);
          end
        end
        RUN: begin
          cdiv <= cdiv_nxt;
          // Grant only after the current CPU step finishes.
          if (ce2H && dma_req) begin
            state   <= DMA;
            dma_gnt <= 1'b1;
            ce2H    <= 1'b0;
          end else begin
            ce2H <= (cdiv == CLAST);
          end
        end
        DMA: begin
          cdiv <= cdiv_nxt;
          if (!dma_req) begin
            state   <= RUN;
            dma_gnt <= 1'b0;
            ce2H    <= (cdiv == CLAST);
          end else begin
            dma_gnt <= 1'b1;
            ce2H    <= 1'b0;
          end
        end
        default: begin
          state   <= HOLD;
          cdiv    <= '0;
          rcnt    <= '0;
          ce2H    <= 1'b0;
          dma_gnt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: cycle model
// compare plus directed latency/edge checks.
module tb_cpu_sequencer;

  localparam int CE_DIV      = 4;
  localparam int IRQ_BIT     = 5;
  localparam int WDOG_FRAMES = 8;
  localparam int RST_CYCLES  = 16;

  logic clk = 1'b0;
  logic reset;
  logic line_strobe;
  logic frame_start;
  logic wdog_kick;
  logic dma_req;
  logic ce2H;
  logic IRQCLK;
  logic dma_gnt;
  logic cpu_reset_n;
  logic wdog_fired;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(
    .CE_DIV     (CE_DIV),
    .IRQ_BIT    (IRQ_BIT),
    .WDOG_FRAMES(WDOG_FRAMES),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .line_strobe(line_strobe),
    .frame_start(frame_start),
    .wdog_kick  (wdog_kick),
    .dma_req    (dma_req),
    .ce2H       (ce2H),
    .IRQCLK     (IRQCLK),
    .dma_gnt    (dma_gnt),
    .cpu_reset_n(cpu_reset_n),
    .wdog_fired (wdog_fired)
  );

  // Behavioural model: CPU age since leaving reset, frame and line counts.
  bit   m_running;
  bit   m_gnt;
  bit   m_fire;
  int   m_hold;
  int   m_age;
  int   m_frames;
  int   m_line;
  logic e_ce, e_irq, e_gnt, e_rstn, e_fired;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_running = 0; m_gnt = 0; m_hold = 0; m_age = 0;
      m_frames = 0; m_line = 0;
      e_ce = 0; e_irq = 0; e_gnt = 0; e_rstn = 0; e_fired = 0;
    end else begin
      e_irq = ((m_line >> IRQ_BIT) & 1) != 0;
      if (frame_start) m_line = 0;
      else if (line_strobe) m_line = (m_line + 1) % 256;
      m_fire = 0;
      if (wdog_kick) m_frames = 0;
      else if (m_running && frame_start) begin
        m_frames = m_frames + 1;
        if (m_frames == WDOG_FRAMES) begin
          m_fire = 1;
          m_frames = 0;
        end
      end
      e_fired = m_fire;
      if (m_fire) begin
        m_running = 0; m_hold = 0; m_gnt = 0;
      end else if (!m_running) begin
        m_hold = m_hold + 1;
        if (m_hold == RST_CYCLES) begin
          m_running = 1; m_age = 0; m_hold = 0;
        end
      end else begin
        if (!m_gnt && e_ce && dma_req) m_gnt = 1;
        else if (m_gnt && !dma_req) m_gnt = 0;
        m_age = m_age + 1;
      end
      e_rstn = m_running;
      e_gnt  = m_gnt;
      e_ce   = m_running && !m_gnt && m_age > 0
            && (m_age % CE_DIV) == 0;
    end
  end

  task automatic chk_bit(input string name, input logic act,
                         input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act,
                         input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk_bit("m_ce2H", ce2H, e_ce);
    chk_bit("m_irq", IRQCLK, e_irq);
    chk_bit("m_gnt", dma_gnt, e_gnt);
    chk_bit("m_rstn", cpu_reset_n, e_rstn);
    chk_bit("m_fired", wdog_fired, e_fired);
    chk_bit("ce_gnt_excl", ce2H && dma_gnt, 1'b0);
  end

  function automatic logic sig(input int s);
    case (s)
      0:       return ce2H;
      1:       return dma_gnt;
      2:       return cpu_reset_n;
      3:       return wdog_fired;
      default: return IRQCLK;
    endcase
  endfunction

  task automatic count_until(input string name, input int s,
                             input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sig(s) !== 1'b1 && n < limit);
    if (sig(s) !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles", name, n);
    end
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic kick();
    @(negedge clk);
    wdog_kick = 1'b1;
    @(negedge clk);
    wdog_kick = 1'b0;
  endtask

  task automatic seven_frames();
    kick();
    repeat (WDOG_FRAMES - 1) begin
      pulse_frame();
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    int  n;
    int  rises;
    int  r1;
    int  r2;
    bit  seen;
    logic prev;

    reset = 1'b0;
    line_strobe = 1'b0;
    frame_start = 1'b0;
    wdog_kick = 1'b0;
    dma_req = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk_bit("rst_ce2H", ce2H, 1'b0);
    chk_bit("rst_irq", IRQCLK, 1'b0);
    chk_bit("rst_gnt", dma_gnt, 1'b0);
    chk_bit("rst_rstn", cpu_reset_n, 1'b0);
    chk_bit("rst_fired", wdog_fired, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    count_until("rst_release", 2, 100, n);
    chk_int("rst_len", n, 16);
    count_until("first_ce", 0, 64, n);
    chk_int("first_ce", n, 4);
    count_until("ce_period", 0, 64, n);
    chk_int("ce_period", n, 4);

    // DMA request one cycle after a ce2H pulse.
    @(negedge clk);
    @(negedge clk);
    dma_req = 1'b1;
    count_until("dma_gnt", 1, 64, n);
    chk_int("gnt_lat", n, 4);
    repeat (10) @(negedge clk);
    dma_req = 1'b0;
    @(posedge clk);
    #1;
    chk_bit("gnt_drop", dma_gnt, 1'b0);
    count_until("ce_resume", 0, 64, n);
    chk_bit("ce_resume_le", (n + 1) <= CE_DIV, 1'b1);

    // One full frame of line strobes.
    kick();
    pulse_frame();
    rises = 0; r1 = -1; r2 = -1;
    prev = IRQCLK;
    for (int i = 0; i < 259; i++) begin
      line_strobe = (i < 256);
      @(negedge clk);
      if (IRQCLK && !prev) begin
        rises++;
        if (r1 < 0) r1 = i;
        else if (r2 < 0) r2 = i;
      end
      prev = IRQCLK;
    end
    line_strobe = 1'b0;
    chk_int("irq_rises", rises, 4);
    chk_int("irq_period", r2 - r1, 64);

    pulse_frame();
    line_strobe = 1'b1;
    repeat (40) @(negedge clk);
    line_strobe = 1'b0;
    repeat (2) @(negedge clk);
    chk_bit("irq_mid_hi", IRQCLK, 1'b1);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    chk_bit("irq_restart", IRQCLK, 1'b0);

    // Watchdog expiry with no kicks.
    seven_frames();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    chk_bit("wdog_fire", wdog_fired, 1'b1);
    chk_bit("wdog_hold", cpu_reset_n, 1'b0);
    @(negedge clk);
    frame_start = 1'b0;
    count_until("wdog_release", 2, 100, n);
    chk_int("wdog_rst_len", n, 16);

    // Kick coincident with the expiring frame.
    seven_frames();
    @(negedge clk);
    frame_start = 1'b1;
    wdog_kick = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wdog_kick = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (wdog_fired || !cpu_reset_n) seen = 1;
    end
    chk_int("kick_wins", int'(seen), 0);

    // Watchdog fires while DMA holds the bus.
    seven_frames();
    @(negedge clk);
    dma_req = 1'b1;
    count_until("wdog_dma_gnt", 1, 64, n);
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    chk_bit("wdog_dma_abort", dma_gnt, 1'b0);
    chk_bit("wdog_dma_fire", wdog_fired, 1'b1);
    @(negedge clk);
    frame_start = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (dma_gnt) seen = 1;
    end
    chk_int("hold_ignores_dma", int'(seen), 0);
    count_until("dma_rerun", 2, 100, n);
    count_until("dma_regnt", 1, 64, n);

    // Async reset in the middle of a DMA grant.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk_bit("async_ce2H", ce2H, 1'b0);
    chk_bit("async_irq", IRQCLK, 1'b0);
    chk_bit("async_gnt", dma_gnt, 1'b0);
    chk_bit("async_rstn", cpu_reset_n, 1'b0);
    chk_bit("async_fired", wdog_fired, 1'b0);
    @(negedge clk);
    dma_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Sequences the 6502 core, which runs on a shared `clk` gated by a `ce2H` clock enable. The block generates `ce2H` and the IRQ timebase `IRQCLK` from video line timing. It arbitrates the CPU bus against a single DMA requester and owns the CPU reset line, including a frame-based watchdog. It sits between the video timing generator, the address decoder (which supplies `wdog_kick`) and the CPU wrapper (`reset_n`, `ce2H`, `IRQCLK`).

## Interface
Parameters:
- `CE_DIV`, 4: `clk` cycles per CPU cycle; legal range ≥2.
- `IRQ_BIT`, 5: line-counter bit driven out as `IRQCLK` (bit 5 = 32V, which gives 4 IRQs per 256-line frame).
- `WDOG_FRAMES`, 8: frames without a kick before the watchdog fires; legal range ≥1.
- `RST_CYCLES`, 16: `clk` cycles that `cpu_reset_n` is held low; legal range ≥1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `line_strobe` in 1: one-`clk` pulse per scanline.
- `frame_start` in 1: one-`clk` pulse per frame (line 0).
- `wdog_kick` in 1: one-`clk` watchdog clear strobe from the decoder.
- `dma_req` in 1: DMA bus request, level.
- `ce2H` out 1: CPU clock enable, one-`clk` pulse.
- `IRQCLK` out 1: IRQ timebase level to the CPU wrapper.
- `dma_gnt` out 1: bus granted to DMA; the CPU is stalled while this is high.
- `cpu_reset_n` out 1: active-low reset to the CPU wrapper.
- `wdog_fired` out 1: one-`clk` pulse when the watchdog expires.

## Operation
- **States:** `HOLD`, `RUN`, `DMA`.
- **Reset values:**
  - Outputs: `ce2H`=0, `IRQCLK`=0, `dma_gnt`=0, `cpu_reset_n`=0, `wdog_fired`=0.
  - Internal: state=`HOLD`, all counters 0.
- **Divider `cdiv`:**
  - Counts 0..`CE_DIV`-1 and wraps.
  - Runs in every state, except that it is forced to 0 while in `HOLD`.
- **`HOLD` state:**
  - `cpu_reset_n`=0, `ce2H`=0, `dma_gnt`=0.
  - `rcnt` increments each `clk`.
  - When `rcnt` reaches `RST_CYCLES`-1: go to `RUN`, clear `rcnt`, set `cpu_reset_n` to 1.
- **`RUN` state:**
  - `ce2H`=1 in every cycle where `cdiv`==`CE_DIV`-1.
  - If `dma_req`=1 at the edge ending a `ce2H` cycle, go to `DMA`. That CPU step still completes.
- **`DMA` state:**
  - `dma_gnt`=1 and `ce2H`=0.
  - When `dma_req`=0 at any edge, go to `RUN`. The next `ce2H` follows at the next `cdiv`==`CE_DIV`-1.
- **Watchdog:**
  - `wcnt` (width `$clog2(WDOG_FRAMES+1)`) increments on `frame_start`.
  - `wdog_kick` clears `wcnt` to 0. A kick wins over a simultaneous `frame_start`.
  - The watchdog fires on a `frame_start` edge where `wcnt`==`WDOG_FRAMES`-1 and no kick is present. On firing:
    - `wdog_fired` pulses.
    - `wcnt` clears to 0.
    - State goes to `HOLD` from any state, aborting `DMA`: `dma_gnt` drops the next cycle.
  - The watchdog does not count while in `HOLD`.
- **Line counter `lc`:**
  - 8 bits.
  - Cleared by `frame_start`; incremented by `line_strobe`, wrapping 255→0.
  - `frame_start` wins over a simultaneous `line_strobe`.
  - `IRQCLK` is a registered copy of `lc[IRQ_BIT]`. It is independent of state and keeps running in `HOLD`.
- **Priority at a single edge:** `reset` > watchdog fire > DMA transitions > normal run.

## Timing
- All outputs are registered and change only on the `clk` edge (or on async `reset` assertion).
- Latencies:
  - `dma_req` sampled on a `ce2H` cycle → `dma_gnt` high the next cycle.
  - Worst-case grant latency: `CE_DIV` cycles.
  - `dma_req` drops → `dma_gnt` low the next cycle.
  - First `ce2H` after release: ≤`CE_DIV` cycles later.
- `ce2H` and `dma_gnt` are never high in the same cycle.
- `IRQCLK` lags `lc` by 1 `clk`.
- Reset release → `cpu_reset_n` rises after exactly `RST_CYCLES` cycles. First `ce2H` is `CE_DIV` cycles after that.
- `reset` asserted mid-`DMA` → `dma_gnt`=0 immediately; state goes to `HOLD`.

## Structure
- Package `cpu_seq_pkg`:
  - State enum `seq_state_t` {`HOLD`, `RUN`, `DMA`}.
  - Default parameter constants.
- Sub-module `cpu_watchdog`:
  - Contains `wcnt`, kick/frame priority and the `wdog_fired` pulse.
  - Inputs: `frame_start`, `wdog_kick`, an enable (state≠`HOLD`).
- The parent holds the FSM, `cdiv`, `rcnt` and `lc`.

## Test plan
- Reset sequence, default parameters → `cpu_reset_n` low 16 cycles after release; `ce2H` pulses every 4th cycle thereafter; `dma_gnt`=0.
- Assert `dma_req` 1 cycle after a `ce2H` pulse → grant at the cycle after the next `ce2H` (≤4 cycles); no `ce2H` while granted; drop `dma_req` → `dma_gnt` low next cycle and `ce2H` resumes within 4 cycles.
- 256 `line_strobe`s per `frame_start`, `IRQ_BIT`=5 → `IRQCLK` square wave with period 64 lines (4 rising edges per frame); `frame_start` mid-frame restarts it low.
- No kicks for 8 frames → `wdog_fired` on the 8th `frame_start`; `cpu_reset_n` low 16 cycles; kick coincident with the 8th `frame_start` → no fire.
- Watchdog fire while `dma_gnt`=1 → `dma_gnt` low next cycle; `HOLD` entered; `dma_req` ignored until `RUN`.
- Async `reset` pulse mid-`DMA` → all outputs return to reset values immediately.
